// File: rtl/strange_device_bank.sv
// strange_device_bank: CHANNELS independent digit-history buffers with
// edge-detected button inputs, per-channel hold/auto-rotate display and a
// shared load-acknowledge indicator.
module strange_device_bank #(
    parameter int CHANNELS      = 4,
    parameter int SEL_WIDTH     = 2,
    parameter int DIGIT_WIDTH   = 7,
    parameter int DEPTH         = 4,
    parameter int DISPLAY_WIDTH = 8,
    parameter int ROTATE_CYCLES = 16,
    parameter int IND_CYCLES    = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [SEL_WIDTH-1:0]              device_choice,
    input  logic [DIGIT_WIDTH-1:0]            digit_choice,
    input  logic                              digit_load,
    input  logic                              digit_change,
    input  logic                              mode_change,
    output logic [CHANNELS*DISPLAY_WIDTH-1:0] displays_flattened,
    output logic                              digit_load_indicator,
    output logic [CHANNELS-1:0]               buffer_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(ROTATE_CYCLES);
    localparam int IW = $clog2(IND_CYCLES + 1);

    typedef enum logic {
        HOLD = 1'b0,
        AUTO = 1'b1
    } mode_t;

    logic [SEL_WIDTH-1:0]   device_choice_q;
    logic [DIGIT_WIDTH-1:0] digit_choice_q;
    logic                   load_q, load_qq;
    logic                   change_q, change_qq;
    logic                   mode_q, mode_qq;

    logic [DIGIT_WIDTH-1:0] buf_mem [CHANNELS][DEPTH];
    logic [PW-1:0]          wr_ptr   [CHANNELS];
    logic [PW-1:0]          disp_ptr [CHANNELS];
    logic [CW-1:0]          count    [CHANNELS];
    logic [RW-1:0]          rot_cnt  [CHANNELS];
    mode_t                  mode     [CHANNELS];
    logic [IW-1:0]          ind_cnt;

    logic                   sel_ok, load_ev, change_ev, mode_ev;
    logic [CHANNELS-1:0]    hit, do_load, chg_eff, do_mode, wrap, do_adv, clr_rot;
    logic [CW-1:0]          ptr_inc  [CHANNELS];
    logic [PW-1:0]          nxt_ptr  [CHANNELS];

    assign sel_ok    = 32'(device_choice_q) < 32'(CHANNELS);
    assign load_ev   = load_q & ~load_qq;
    assign change_ev = change_q & ~change_qq;
    assign mode_ev   = mode_q & ~mode_qq;

    // Per-channel event decode; change uses the pre-load count and wins over the auto wrap
    always_comb begin
        hit     = '0;
        do_load = '0;
        chg_eff = '0;
        do_mode = '0;
        wrap    = '0;
        do_adv  = '0;
        clr_rot = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            ptr_inc[c] = '0;
            nxt_ptr[c] = '0;
        end
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            hit[c]     = sel_ok && (32'(device_choice_q) == c);
            do_load[c] = hit[c] && load_ev && (count[c] != CW'(DEPTH));
            chg_eff[c] = hit[c] && change_ev && (count[c] != '0);
            do_mode[c] = hit[c] && mode_ev;
            wrap[c]    = (mode[c] == AUTO) && (rot_cnt[c] == RW'(ROTATE_CYCLES - 1));
            do_adv[c]  = chg_eff[c] || (wrap[c] && (count[c] > CW'(1)));
            clr_rot[c] = chg_eff[c] || do_mode[c] || (mode[c] == HOLD) || wrap[c];
            ptr_inc[c] = CW'(disp_ptr[c]) + CW'(1);
            nxt_ptr[c] = (ptr_inc[c] >= count[c]) ? '0 : disp_ptr[c] + PW'(1);
        end
    end

    // Input capture, per-channel buffer/pointer/mode state and indicator timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            device_choice_q <= '0;
            digit_choice_q  <= '0;
            load_q          <= 1'b0;
            load_qq         <= 1'b0;
            change_q        <= 1'b0;
            change_qq       <= 1'b0;
            mode_q          <= 1'b0;
            mode_qq         <= 1'b0;
            ind_cnt         <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    buf_mem[c][e] <= '0;
                end
                wr_ptr[c]   <= '0;
                disp_ptr[c] <= '0;
                count[c]    <= '0;
                rot_cnt[c]  <= '0;
                mode[c]     <= HOLD;
            end
        end else begin
            device_choice_q <= device_choice;
            digit_choice_q  <= digit_choice;
            load_q          <= digit_load;
            load_qq         <= load_q;
            change_q        <= digit_change;
            change_qq       <= change_q;
            mode_q          <= mode_change;
            mode_qq         <= mode_q;

            if (|do_load) begin
                ind_cnt <= IW'(IND_CYCLES);
            end else if (ind_cnt != '0) begin
                ind_cnt <= ind_cnt - IW'(1);
            end

            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (do_load[c]) begin
                    buf_mem[c][wr_ptr[c]] <= digit_choice_q;
                    wr_ptr[c]             <= wr_ptr[c] + PW'(1);
                    count[c]              <= count[c] + CW'(1);
                end
                if (do_adv[c]) begin
                    disp_ptr[c] <= nxt_ptr[c];
                end
                rot_cnt[c] <= clr_rot[c] ? '0 : rot_cnt[c] + RW'(1);
                if (do_mode[c]) begin
                    mode[c] <= (mode[c] == HOLD) ? AUTO : HOLD;
                end
            end
        end
    end

    // Output decode from registered state
    always_comb begin
        displays_flattened   = '0;
        buffer_full          = '0;
        digit_load_indicator = (ind_cnt != '0);
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            buffer_full[c] = (count[c] == CW'(DEPTH));
            if (count[c] != '0) begin
                displays_flattened[c*DISPLAY_WIDTH + DISPLAY_WIDTH - 1] = 1'b1;
                displays_flattened[c*DISPLAY_WIDTH +: DIGIT_WIDTH]      = buf_mem[c][disp_ptr[c]];
            end
        end
    end

endmodule

// File: tb/tb_strange_device_bank.sv
// Testbench for strange_device_bank: directed test-plan sequences plus
// randomized button traffic, checked cycle-by-cycle through a scoreboard
// fed by a behavioural model of the channel histories.
module tb_strange_device_bank;

    localparam int CH    = 3;
    localparam int DEPTH = 4;
    localparam int ROT   = 16;
    localparam int IND   = 8;
    localparam int DW    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        device_choice;
    logic [6:0]        digit_choice;
    logic              digit_load, digit_change, mode_change;
    logic [CH*DW-1:0]  displays_flattened;
    logic              digit_load_indicator;
    logic [CH-1:0]     buffer_full;

    strange_device_bank #(
        .CHANNELS(CH), .SEL_WIDTH(2), .DIGIT_WIDTH(7), .DEPTH(DEPTH),
        .DISPLAY_WIDTH(DW), .ROTATE_CYCLES(ROT), .IND_CYCLES(IND)
    ) dut (
        .clk(clk), .rst(rst), .device_choice(device_choice),
        .digit_choice(digit_choice), .digit_load(digit_load),
        .digit_change(digit_change), .mode_change(mode_change),
        .displays_flattened(displays_flattened),
        .digit_load_indicator(digit_load_indicator),
        .buffer_full(buffer_full)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] hist [CH][DEPTH];   // loaded digits in load order
    int         n     [CH];         // number of digits held
    int         disp  [CH];         // index of displayed digit
    int         dwell [CH];         // clocks spent on current digit in auto mode
    bit         autom [CH];
    int         ind;
    bit         p_ld, p_cg, p_md;   // events seen at the last edge, applied at the next
    int         p_sel;
    logic [6:0] p_dig;
    bit         last_ld, last_cg, last_md;

    typedef struct {
        logic [CH*DW-1:0] d;
        logic             i;
        logic [CH-1:0]    f;
    } exp_t;
    exp_t exp_q[$];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            n[c] = 0; disp[c] = 0; dwell[c] = 0; autom[c] = 0;
        end
        ind = 0;
        p_ld = 0; p_cg = 0; p_md = 0; p_sel = 0; p_dig = '0;
        last_ld = 0; last_cg = 0; last_md = 0;
    endtask

    task automatic model_step();
        bit accepted;
        bit hit, cg;
        int n0;
        accepted = 0;
        for (int c = 0; c < CH; c++) begin
            hit = (p_sel == c);
            n0  = n[c];
            cg  = hit && p_cg && (n0 > 0);
            if (hit && p_ld && n0 < DEPTH) begin
                hist[c][n0] = p_dig;
                n[c] = n0 + 1;
                accepted = 1;
            end
            if (cg) begin
                disp[c] = (disp[c] + 1) % n0;
                dwell[c] = 0;
            end else if (autom[c]) begin
                if (dwell[c] == ROT - 1) begin
                    dwell[c] = 0;
                    if (n0 > 1) disp[c] = (disp[c] + 1) % n0;
                end else begin
                    dwell[c]++;
                end
            end else begin
                dwell[c] = 0;
            end
            if (hit && p_md) begin
                autom[c] = !autom[c];
                dwell[c] = 0;
            end
        end
        if (accepted) ind = IND;
        else if (ind > 0) ind--;
        p_ld  = digit_load && !last_ld;
        p_cg  = digit_change && !last_cg;
        p_md  = mode_change && !last_md;
        p_sel = int'(device_choice);
        p_dig = digit_choice;
        last_ld = digit_load; last_cg = digit_change; last_md = mode_change;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.d = '0;
        e.f = '0;
        for (int c = 0; c < CH; c++) begin
            if (n[c] > 0) e.d[c*DW +: DW] = {1'b1, hist[c][disp[c]]};
            e.f[c] = (n[c] == DEPTH);
        end
        e.i = (ind > 0);
        return e;
    endfunction

    // Model advances on every rising edge and queues what the DUT must show
    always @(posedge clk) begin
        if (!rst) model_reset();
        else model_step();
        exp_q.push_back(model_out());
    end

    // Monitor: sample just after each edge and compare against the oldest expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("sb_disp", 32'(displays_flattened), 32'(e.d));
            check("sb_ind",  32'(digit_load_indicator), 32'(e.i));
            check("sb_full", 32'(buffer_full), 32'(e.f));
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input logic [1:0] sel, input logic [6:0] d,
                         input bit ld, input bit cg, input bit md);
        @(negedge clk);
        device_choice = sel; digit_choice = d;
        digit_load = ld; digit_change = cg; mode_change = md;
        @(negedge clk);
        digit_load = 1'b0; digit_change = 1'b0; mode_change = 1'b0;
    endtask

    function automatic logic [7:0] field(input int c);
        logic [CH*DW-1:0] v;
        v = displays_flattened;
        return v[c*DW +: DW];
    endfunction

    logic [7:0] step_exp [4];
    int         hi;

    initial begin
        model_reset();
        rst = 1'b0;
        device_choice = '0; digit_choice = '0;
        digit_load = 1'b0; digit_change = 1'b0; mode_change = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_disp", 32'(displays_flattened), 32'd0);
        check("rst_ind",  32'(digit_load_indicator), 32'd0);
        check("rst_full", 32'(buffer_full), 32'd0);
        rst = 1'b1;

        // single load on channel 0 and indicator pulse length
        press(2'd0, 7'h01, 1, 0, 0);
        @(posedge clk); #1;
        check("load0_field0", 32'(field(0)), 32'h81);
        check("load0_field1", 32'(field(1)), 32'h00);
        hi = int'(digit_load_indicator);
        repeat (11) begin
            @(posedge clk); #1;
            hi += int'(digit_load_indicator);
        end
        check("ind_len", 32'(hi), 32'(IND));

        // fill channel 1, overflow load, then step through entries
        press(2'd1, 7'h05, 1, 0, 0);
        press(2'd1, 7'h06, 1, 0, 0);
        press(2'd1, 7'h07, 1, 0, 0);
        press(2'd1, 7'h08, 1, 0, 0);
        repeat (10) @(negedge clk);
        press(2'd1, 7'h09, 1, 0, 0);
        @(posedge clk); #1;
        check("ovf_ind",  32'(digit_load_indicator), 32'd0);
        check("ovf_full", 32'(buffer_full), 32'b010);
        step_exp[0] = 8'h86; step_exp[1] = 8'h87; step_exp[2] = 8'h88; step_exp[3] = 8'h85;
        for (int k = 0; k < 4; k++) begin
            press(2'd1, 7'h00, 0, 1, 0);
            @(posedge clk); #1;
            check("step_field1", 32'(field(1)), 32'(step_exp[k]));
        end

        // out-of-range channel is ignored
        repeat (10) @(negedge clk);
        press(2'd3, 7'h41, 1, 1, 1);
        @(posedge clk); #1;
        check("bad_sel_ind", 32'(digit_load_indicator), 32'd0);

        // channel 2 auto rotation, then freeze
        press(2'd2, 7'h10, 1, 0, 0);
        press(2'd2, 7'h20, 1, 0, 0);
        press(2'd2, 7'h00, 0, 0, 1);
        @(posedge clk); #1;
        check("auto_start", 32'(field(2)), 32'h90);
        repeat (45) @(negedge clk);
        press(2'd2, 7'h00, 0, 0, 1);
        repeat (40) @(negedge clk);

        // simultaneous load and change on single-entry channel 0
        press(2'd0, 7'h02, 1, 1, 0);
        @(posedge clk); #1;
        check("ldchg_field0", 32'(field(0)), 32'h81);

        // reset mid-rotation with indicator running
        press(2'd2, 7'h00, 0, 0, 1);
        press(2'd2, 7'h30, 1, 0, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_disp", 32'(displays_flattened), 32'd0);
        check("midrst_ind",  32'(digit_load_indicator), 32'd0);
        check("midrst_full", 32'(buffer_full), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        press(2'd1, 7'h05, 1, 0, 0);
        @(posedge clk); #1;
        check("fresh_field1", 32'(field(1)), 32'h85);
        check("fresh_ind",    32'(digit_load_indicator), 32'd1);

        // randomized traffic with occasional resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            device_choice = 2'($urandom_range(0, 3));
            digit_choice  = 7'($urandom);
            digit_load    = ($urandom_range(0, 3) == 0);
            digit_change  = ($urandom_range(0, 4) == 0);
            mode_change   = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end
        @(negedge clk);
        digit_load = 1'b0; digit_change = 1'b0; mode_change = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
